// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg: shared enums and helpers for the
// simulation monitor (watch kinds, run status, FSM state).
package sim_monitor_pkg;

    typedef enum logic [1:0] {
        K_OFF   = 2'd0,
        K_PASS  = 2'd1,
        K_FAIL  = 2'd2,
        K_BREAK = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_HANG = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BREAK = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic status_e kind2status(input kind_e k);
        unique case (k)
            K_PASS:  return ST_PASS;
            K_FAIL:  return ST_FAIL;
            default: return ST_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sim_monitor_watch_match.sv
// watch_match: programmable watch table plus priority match.
// Ports: clk, reset (sync, low), cfg_* table write,
// retire_v/retire_pc probe, hit/hit_kind/hit_idx result.
module watch_match
    import sim_monitor_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_WATCH = 4,
    parameter int IW        = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_we,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [XLEN-1:0] cfg_addr,
    input  kind_e           cfg_kind,
    input  logic            retire_v,
    input  logic [XLEN-1:0] retire_pc,
    output logic            hit,
    output kind_e           hit_kind,
    output logic [IW-1:0]   hit_idx
);

    logic [XLEN-1:0] addr_q [NUM_WATCH];
    kind_e           kind_q [NUM_WATCH];

    logic [NUM_WATCH-1:0] m_pass;
    logic [NUM_WATCH-1:0] m_fail;
    logic [NUM_WATCH-1:0] m_brk;
    logic [IW-1:0]        i_pass;
    logic [IW-1:0]        i_fail;
    logic [IW-1:0]        i_brk;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WATCH; i++) begin
                kind_q[i] <= K_OFF;
                addr_q[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_WATCH; i++) begin
                if (cfg_idx == IW'(i)) begin
                    kind_q[i] <= cfg_kind;
                    addr_q[i] <= cfg_addr;
                end
            end
        end
    end

    // Scan high to low so the lowest matching
    // index of each kind is the one left standing.
    always_comb begin
        m_pass = '0;
        m_fail = '0;
        m_brk  = '0;
        i_pass = '0;
        i_fail = '0;
        i_brk  = '0;
        for (int i = NUM_WATCH - 1; i >= 0; i--) begin
            if (retire_v && retire_pc == addr_q[i]) begin
                unique case (kind_q[i])
                    K_PASS: begin
                        m_pass[i] = 1'b1;
                        i_pass    = IW'(i);
                    end
                    K_FAIL: begin
                        m_fail[i] = 1'b1;
                        i_fail    = IW'(i);
                    end
                    K_BREAK: begin
                        m_brk[i] = 1'b1;
                        i_brk    = IW'(i);
                    end
                    K_OFF: ;
                endcase
            end
        end
    end

    // FAIL outranks PASS, PASS outranks BREAK.
    always_comb begin
        hit      = 1'b0;
        hit_kind = K_OFF;
        hit_idx  = '0;
        if (|m_fail) begin
            hit      = 1'b1;
            hit_kind = K_FAIL;
            hit_idx  = i_fail;
        end else if (|m_pass) begin
            hit      = 1'b1;
            hit_kind = K_PASS;
            hit_idx  = i_pass;
        end else if (|m_brk) begin
            hit      = 1'b1;
            hit_kind = K_BREAK;
            hit_idx  = i_brk;
        end
    end

endmodule

// File: rtl/sim_monitor.sv
// sim_monitor: watches retired PCs, stops on PASS/FAIL/hang,
// halts on BREAK, counts cycles and retires during a run.
// Ports: clk, reset (sync, low), arm, resume, retire_v/pc,
// cfg_* watch writes; done, status, halted, hit_idx,
// hit_pc, cycles, instret.
module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int  XLEN       = 32,
    parameter int  NUM_WATCH  = 4,
    parameter int  CNT_W      = 32,
    parameter int  HANG_LIMIT = 1024,
    localparam int IW = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             retire_v,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [XLEN-1:0]  cfg_addr,
    input  logic [1:0]       cfg_kind,
    input  logic             resume,
    output logic             done,
    output logic [1:0]       status,
    output logic             halted,
    output logic [IW-1:0]    hit_idx,
    output logic [XLEN-1:0]  hit_pc,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret
);

    localparam int HW = $clog2(HANG_LIMIT + 1);
    localparam logic [HW-1:0] HANG_LAST = HW'(HANG_LIMIT - 1);

    state_e          state_q;
    state_e          state_d;
    status_e         status_q;
    status_e         status_d;
    logic            take_hit;
    logic            hang_now;
    logic [HW-1:0]   idle_q;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0] last_pc_q;
    logic [XLEN-1:0] hit_pc_q;
    logic [IW-1:0]   hit_idx_q;

    logic            m_hit;
    kind_e           m_kind;
    logic [IW-1:0]   m_idx;

    watch_match #(
        .XLEN      (XLEN),
        .NUM_WATCH (NUM_WATCH),
        .IW        (IW)
    ) u_match (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_addr  (cfg_addr),
        .cfg_kind  (kind_e'(cfg_kind)),
        .retire_v  (retire_v),
        .retire_pc (retire_pc),
        .hit       (m_hit),
        .hit_kind  (m_kind),
        .hit_idx   (m_idx)
    );

    // A retire in the would-be hang cycle clears the
    // idle count instead, so it always beats the hang.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        take_hit = 1'b0;
        hang_now = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_RUN;
            end
            S_RUN: begin
                if (m_hit) begin
                    take_hit = 1'b1;
                    if (m_kind == K_BREAK) begin
                        state_d = S_BREAK;
                    end else begin
                        state_d  = S_DONE;
                        status_d = kind2status(m_kind);
                    end
                end else if (!retire_v && idle_q == HANG_LAST) begin
                    hang_now = 1'b1;
                    state_d  = S_DONE;
                    status_d = ST_HANG;
                end
            end
            S_BREAK: begin
                if (resume) state_d = S_RUN;
            end
            S_DONE: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            status_q  <= ST_NONE;
            idle_q    <= '0;
            cycles_q  <= '0;
            instret_q <= '0;
            last_pc_q <= '0;
            hit_pc_q  <= '0;
            hit_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (state_q == S_IDLE && arm) begin
                idle_q    <= '0;
                cycles_q  <= '0;
                instret_q <= '0;
                last_pc_q <= '0;
            end
            if (state_q == S_RUN) begin
                if (~&cycles_q) cycles_q <= cycles_q + 1'b1;
                if (retire_v) begin
                    if (~&instret_q) instret_q <= instret_q + 1'b1;
                    idle_q    <= '0;
                    last_pc_q <= retire_pc;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
            end
            if (take_hit) begin
                hit_idx_q <= m_idx;
                hit_pc_q  <= retire_pc;
            end
            if (hang_now) hit_pc_q <= last_pc_q;
        end
    end

    assign done    = (state_q == S_DONE);
    assign halted  = (state_q == S_BREAK);
    assign status  = status_q;
    assign hit_idx = hit_idx_q;
    assign hit_pc  = hit_pc_q;
    assign cycles  = cycles_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_sim_monitor.sv
// tb_sim_monitor: scoreboard bench for sim_monitor.
// Expected stops are queued at stimulus, checked on output.
module tb_sim_monitor;

    localparam int XLEN = 32;
    localparam int NW   = 4;
    localparam int CW   = 4;
    localparam int HL   = 8;

    logic            clk       = 1'b0;
    logic            reset     = 1'b0;
    logic            arm       = 1'b0;
    logic            retire_v  = 1'b0;
    logic [XLEN-1:0] retire_pc = '0;
    logic            cfg_we    = 1'b0;
    logic [1:0]      cfg_idx   = '0;
    logic [XLEN-1:0] cfg_addr  = '0;
    logic [1:0]      cfg_kind  = '0;
    logic            resume    = 1'b0;
    logic            done;
    logic [1:0]      status;
    logic            halted;
    logic [1:0]      hit_idx;
    logic [XLEN-1:0] hit_pc;
    logic [CW-1:0]   cycles;
    logic [CW-1:0]   instret;

    typedef struct {
        logic        done;
        logic [1:0]  status;
        logic        halted;
        logic [1:0]  idx;
        logic [31:0] pc;
        logic [3:0]  instret;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    sim_monitor #(
        .XLEN       (XLEN),
        .NUM_WATCH  (NW),
        .CNT_W      (CW),
        .HANG_LIMIT (HL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .retire_v  (retire_v),
        .retire_pc (retire_pc),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_addr  (cfg_addr),
        .cfg_kind  (cfg_kind),
        .resume    (resume),
        .done      (done),
        .status    (status),
        .halted    (halted),
        .hit_idx   (hit_idx),
        .hit_pc    (hit_pc),
        .cycles    (cycles),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic cfg(input int idx, input int addr,
                       input int kind);
        cfg_we   = 1'b1;
        cfg_idx  = 2'(idx);
        cfg_addr = 32'(addr);
        cfg_kind = 2'(kind);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic retire(input int pc);
        retire_v  = 1'b1;
        retire_pc = 32'(pc);
        tick();
        retire_v  = 1'b0;
    endtask

    task automatic push(input logic d, input int st,
                        input logic h, input int idx,
                        input int pc, input int ir);
        exp_t e;
        e.done    = d;
        e.status  = 2'(st);
        e.halted  = h;
        e.idx     = 2'(idx);
        e.pc      = 32'(pc);
        e.instret = 4'(ir);
        sb.push_back(e);
    endtask

    task automatic wait_out(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!done && !halted && n < 16) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "/done"}, 64'(done), 64'(e.done));
            chk({tag, "/status"}, 64'(status), 64'(e.status));
            chk({tag, "/halted"}, 64'(halted), 64'(e.halted));
            chk({tag, "/hit_idx"}, 64'(hit_idx), 64'(e.idx));
            chk({tag, "/hit_pc"}, 64'(hit_pc), 64'(e.pc));
            chk({tag, "/instret"}, 64'(instret), 64'(e.instret));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/done"}, 64'(done), 64'd0);
        chk({tag, "/status"}, 64'(status), 64'd0);
        chk({tag, "/halted"}, 64'(halted), 64'd0);
        chk({tag, "/hit_idx"}, 64'(hit_idx), 64'd0);
        chk({tag, "/hit_pc"}, 64'(hit_pc), 64'd0);
        chk({tag, "/cycles"}, 64'(cycles), 64'd0);
        chk({tag, "/instret"}, 64'(instret), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset state
        tick();
        tick();
        chk_zero("rst");
        reset = 1'b1;

        // basic PASS; IDLE retires ignored; DONE terminal
        cfg(0, 'h100, 1);
        retire('h100);
        chk("idle_ret/done", 64'(done), 64'd0);
        do_arm();
        retire('h0F8);
        retire('h0FC);
        push(1'b1, 1, 1'b0, 0, 'h100, 3);
        retire('h100);
        chk("pass/latency", 64'(done), 64'd1);
        wait_out("pass");
        chk("pass/cycles", 64'(cycles), 64'd3);
        arm      = 1'b1;
        resume   = 1'b1;
        retire('h0FC);
        arm      = 1'b0;
        resume   = 1'b0;
        chk("term/done", 64'(done), 64'd1);
        chk("term/status", 64'(status), 64'd1);
        chk("term/instret", 64'(instret), 64'd3);
        chk("term/cycles", 64'(cycles), 64'd3);

        // FAIL beats PASS beats BREAK
        do_reset();
        cfg(0, 'h200, 3);
        cfg(1, 'h200, 1);
        cfg(2, 'h200, 2);
        cfg(3, 'h200, 2);
        do_arm();
        push(1'b1, 2, 1'b0, 2, 'h200, 1);
        retire('h200);
        wait_out("prio_fail");

        // lowest PASS index wins, PASS beats BREAK
        do_reset();
        cfg(3, 'h300, 1);
        cfg(1, 'h300, 1);
        cfg(0, 'h300, 3);
        do_arm();
        push(1'b1, 1, 1'b0, 1, 'h300, 1);
        retire('h300);
        wait_out("prio_pass");

        // BREAK, ignored retires, resume, then PASS
        do_reset();
        cfg(3, 'h40, 3);
        cfg(0, 'h80, 1);
        do_arm();
        retire('h3C);
        push(1'b0, 0, 1'b1, 3, 'h40, 2);
        retire('h40);
        wait_out("brk");
        retire('h44);
        retire('h80);
        chk("brk_ign/instret", 64'(instret), 64'd2);
        chk("brk_ign/cycles", 64'(cycles), 64'd2);
        chk("brk_ign/halted", 64'(halted), 64'd1);
        chk("brk_ign/done", 64'(done), 64'd0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume/halted", 64'(halted), 64'd0);
        push(1'b1, 1, 1'b0, 0, 'h80, 3);
        retire('h80);
        wait_out("brk_pass");

        // hang after HL idle cycles
        do_reset();
        do_arm();
        retire('h500);
        repeat (HL - 1) tick();
        chk("hang_pre/done", 64'(done), 64'd0);
        push(1'b1, 3, 1'b0, 0, 'h500, 1);
        tick();
        wait_out("hang");
        chk("hang/cycles", 64'(cycles), 64'd9);

        // retire in the hang cycle wins, idle restarts
        do_reset();
        do_arm();
        repeat (HL - 1) tick();
        retire('h600);
        chk("nohang/done", 64'(done), 64'd0);
        repeat (HL - 1) tick();
        chk("nohang2/done", 64'(done), 64'd0);
        push(1'b1, 3, 1'b0, 0, 'h600, 1);
        tick();
        wait_out("hang2");
        chk("hang2/cycles_sat", 64'(cycles), 64'd15);

        // counter saturation
        do_reset();
        do_arm();
        for (int i = 0; i < 20; i++) retire('h1000 + 4 * i);
        chk("sat/instret", 64'(instret), 64'd15);
        chk("sat/cycles", 64'(cycles), 64'd15);
        chk("sat/done", 64'(done), 64'd0);

        // reset mid-run clears table and outputs
        do_reset();
        cfg(2, 'h700, 2);
        cfg(1, 'h6F0, 3);
        do_arm();
        retire('h6E0);
        push(1'b0, 0, 1'b1, 1, 'h6F0, 2);
        retire('h6F0);
        wait_out("pre_rst");
        reset = 1'b0;
        tick();
        chk_zero("mid_rst");
        // reset outranks arm and cfg_we
        arm      = 1'b1;
        cfg_we   = 1'b1;
        cfg_idx  = 2'd0;
        cfg_addr = 32'h800;
        cfg_kind = 2'd2;
        tick();
        arm      = 1'b0;
        cfg_we   = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        chk("rstprio/cycles", 64'(cycles), 64'd0);
        do_arm();
        retire('h700);
        chk("old_fail/done", 64'(done), 64'd0);
        retire('h6F0);
        chk("old_brk/halted", 64'(halted), 64'd0);
        retire('h800);
        chk("rstprio_cfg/done", 64'(done), 64'd0);
        cfg(3, 'h900, 1);
        push(1'b1, 1, 1'b0, 3, 'h900, 4);
        retire('h900);
        wait_out("run_cfg");

        chk("sb/left", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sim_monitor.md
SIM_MONITOR -- requirements
Module: sim_monitor

Interface
REQ-001 Parameter XLEN, default 32: PC and watch-address width.
REQ-002 Parameter NUM_WATCH, default 4: number of programmable watch entries (1..16).
REQ-003 Parameter CNT_W, default 32: width of the cycle and retired-instruction counters.
REQ-004 Parameter HANG_LIMIT, default 1024: idle cycles without a retire before a hang is declared.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset (0 = reset asserted).
REQ-007 arm  in  1  one-cycle pulse; starts a run from IDLE.
REQ-008 retire_v  in  1  an instruction retires this cycle.
REQ-009 retire_pc  in  XLEN  PC of the retiring instruction; sampled only when retire_v=1.
REQ-010 cfg_we  in  1  write strobe for the watch table.
REQ-011 cfg_idx  in  $clog2(NUM_WATCH) (min 1)  entry to write.
REQ-012 cfg_addr  in  XLEN  watch address.
REQ-013 cfg_kind  in  2  entry kind: 0=OFF, 1=PASS, 2=FAIL, 3=BREAK.
REQ-014 resume  in  1  one-cycle pulse; leaves BREAK state.
REQ-015 done  out  1  run finished (PASS, FAIL or HANG); held until reset.
REQ-016 status  out  2  0=none, 1=pass, 2=fail, 3=hang.
REQ-017 halted  out  1  high while in BREAK.
REQ-018 hit_idx  out  $clog2(NUM_WATCH)  index of the last matching entry.
REQ-019 hit_pc  out  XLEN  PC that caused the last stop, break or hang (last retired PC for hang).
REQ-020 cycles  out  CNT_W  cycles spent in RUN.
REQ-021 instret  out  CNT_W  retires counted in RUN.

Function
REQ-022 States: IDLE, RUN, BREAK, DONE; reset enters IDLE.
REQ-023 IDLE->RUN on arm=1; cycles, instret and the idle counter clear on that same edge.
REQ-024 Table writes take effect the cycle after cfg_we in any state; a write in RUN applies to retires from the next cycle onward.
REQ-025 Match: retire_v=1 and retire_pc equals cfg_addr of an entry whose kind is not OFF; evaluation is combinational within the retire cycle.
REQ-026 Multiple matches: FAIL beats PASS, PASS beats BREAK; among entries of the same kind, the lowest index wins and is reported in hit_idx.
REQ-027 In RUN, a retire increments instret by 1 and a clock edge increments cycles by 1; both counters saturate at all-ones and do not wrap.
REQ-028 The matching retire is counted in instret.
REQ-029 PASS or FAIL match: next cycle state=DONE, done=1, status=1 or 2, hit_pc and hit_idx captured; latency 1 cycle.
REQ-030 BREAK match: next cycle state=BREAK, halted=1; cycles stop counting.
REQ-031 In BREAK, retire_v is ignored.
REQ-032 resume in BREAK returns to RUN the next cycle; resume in any other state is ignored.
REQ-033 The idle counter increments each RUN cycle with retire_v=0 and clears on any retire.
REQ-034 When the idle counter reaches HANG_LIMIT, the block enters DONE with status=3.
REQ-035 If a retire and the hang limit fall in the same cycle, the retire wins and no hang is declared.
REQ-036 DONE is terminal; arm, resume and retires are ignored there; only reset leaves DONE.
REQ-037 arm while in RUN or BREAK is ignored.

Reset
REQ-038 While reset=0 at a rising edge, the state returns to IDLE.
REQ-039 Reset clears every table kind to OFF and sets all outputs to 0, including mid-run and in DONE.
REQ-040 Reset has priority over cfg_we, arm and resume in the same cycle.

Structure
REQ-041 Package sim_monitor_pkg holds the kind enum (OFF/PASS/FAIL/BREAK), the status enum and the state enum.
REQ-042 The watch table plus its priority match logic form sub-module watch_match, which outputs hit, hit_kind and hit_idx.

Verification
REQ-043 Entry0=PASS@0x100, arm, retire 0x0F8, 0x0FC, 0x100 -> done=1 next cycle, status=1, instret=3, hit_pc=0x100.
REQ-044 Entry1=PASS@0x200 and entry2=FAIL@0x200, retire 0x200 -> status=2, hit_idx=2.
REQ-045 Entry3=BREAK@0x40, retire 0x40 -> halted=1; retires during BREAK leave instret unchanged; resume -> RUN; then PASS hit completes normally.
REQ-046 HANG_LIMIT=8, arm, no retires -> status=3 after 8 idle cycles; a retire in the 8th idle cycle -> no hang, idle counter restarts.
REQ-047 CNT_W=4, run 20 retires -> instret saturates at 15.
REQ-048 Reset asserted mid-run after a FAIL entry is programmed -> all outputs 0; after re-arm, retire at the old FAIL address gives no stop.
